// File: rtl/labeler_scan_ctrl.sv
// Raster-scan sequencer for the connected-component labeler: walks the frame,
// feeds each pixel with its left/top neighbour labels and keeps a one-row label line.
module labeler_scan_ctrl #(
    parameter int IMG_W       = 64,
    parameter int IMG_H       = 48,
    parameter int LABEL_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   pix_valid,
    input  logic                   pix_data,
    output logic                   pix_ready,
    output logic                   lbl_enable,
    output logic                   lbl_motion_pixel,
    output logic [LABEL_WIDTH-1:0] lbl_left_label,
    output logic [LABEL_WIDTH-1:0] lbl_top_label,
    input  logic [LABEL_WIDTH-1:0] lbl_current_label,
    input  logic                   lbl_new_label_valid,
    output logic                   busy,
    output logic                   frame_done,
    output logic [LABEL_WIDTH-1:0] label_count,
    output logic                   label_overflow
);

    localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

    typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WRITE, DONE} state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [XW-1:0]          x;
    logic [YW-1:0]          y;
    logic [LABEL_WIDTH-1:0] left_reg;
    logic                   pix_p0;
    logic [LABEL_WIDTH-1:0] top_p0;
    logic [LABEL_WIDTH-1:0] line_buf [IMG_W];
    logic [LABEL_WIDTH-1:0] wb;
    logic [LABEL_WIDTH-1:0] cnt_nxt;
    logic                   ovf_nxt;
    logic                   last_x;
    logic                   last_pix;

    // Saturating increment: returns {hit_ceiling, next_value}.
    function automatic logic [LABEL_WIDTH:0] sat_inc(input logic [LABEL_WIDTH-1:0] v);
        if (&v) begin
            return {1'b1, v};
        end
        return {1'b0, v + LABEL_WIDTH'(1)};
    endfunction

    always_comb begin
        wb                 = pix_p0 ? lbl_current_label : '0;
        last_x             = (x == X_LAST);
        last_pix           = last_x && (y == Y_LAST);
        {ovf_nxt, cnt_nxt} = sat_inc(label_count);
    end

    always_comb begin
        state_nxt        = state;
        pix_ready        = 1'b0;
        lbl_enable       = 1'b0;
        lbl_motion_pixel = 1'b0;
        lbl_left_label   = '0;
        lbl_top_label    = '0;
        busy             = 1'b1;
        frame_done       = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                pix_ready = 1'b1;
                if (pix_valid) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                lbl_enable       = 1'b1;
                lbl_motion_pixel = pix_p0;
                // Frame edges mask neighbours, so stale line-buffer data never leaks out.
                lbl_left_label   = (x == '0) ? '0 : left_reg;
                lbl_top_label    = (y == '0) ? '0 : top_p0;
                state_nxt        = WRITE;
            end
            WRITE: begin
                state_nxt = last_pix ? DONE : FETCH;
            end
            DONE: begin
                frame_done = 1'b1;
                state_nxt  = IDLE;
            end
            default: begin
                busy      = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            x              <= '0;
            y              <= '0;
            left_reg       <= '0;
            label_count    <= '0;
            label_overflow <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                x              <= '0;
                y              <= '0;
                left_reg       <= '0;
                label_count    <= '0;
                label_overflow <= 1'b0;
            end
            if (state == WRITE) begin
                left_reg <= wb;
                if (lbl_new_label_valid) begin
                    label_count <= cnt_nxt;
                    if (ovf_nxt) begin
                        label_overflow <= 1'b1;
                    end
                end
                if (last_x) begin
                    x <= '0;
                    y <= (y == Y_LAST) ? '0 : y + YW'(1);
                end else begin
                    x <= x + XW'(1);
                end
            end
        end
    end

    // Stage p0: pixel capture and line-buffer read on accept; write-back in WRITE.
    always_ff @(posedge clk) begin
        if (state == FETCH && pix_valid) begin
            pix_p0 <= pix_data;
            top_p0 <= line_buf[x];
        end
        if (state == WRITE) begin
            line_buf[x] <= wb;
        end
    end

endmodule

// File: tb/tb_labeler_scan_ctrl.sv
// Scoreboard bench for labeler_scan_ctrl on a 4x3 frame with 2-bit labels.
module tb_labeler_scan_ctrl;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int LW = 2;
    localparam int N  = W * H;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          pix_valid = 1'b0;
    logic          pix_data = 1'b0;
    logic          pix_ready;
    logic          lbl_enable;
    logic          lbl_motion_pixel;
    logic [LW-1:0] lbl_left_label;
    logic [LW-1:0] lbl_top_label;
    logic [LW-1:0] lbl_current_label = '0;
    logic          lbl_new_label_valid = 1'b0;
    logic          busy;
    logic          frame_done;
    logic [LW-1:0] label_count;
    logic          label_overflow;

    labeler_scan_ctrl #(.IMG_W(W), .IMG_H(H), .LABEL_WIDTH(LW)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .start               (start),
        .pix_valid           (pix_valid),
        .pix_data            (pix_data),
        .pix_ready           (pix_ready),
        .lbl_enable          (lbl_enable),
        .lbl_motion_pixel    (lbl_motion_pixel),
        .lbl_left_label      (lbl_left_label),
        .lbl_top_label       (lbl_top_label),
        .lbl_current_label   (lbl_current_label),
        .lbl_new_label_valid (lbl_new_label_valid),
        .busy                (busy),
        .frame_done          (frame_done),
        .label_count         (label_count),
        .label_overflow      (label_overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic          m;
        logic [LW-1:0] l;
        logic [LW-1:0] t;
        int            idx;
    } exp_t;

    exp_t          sb[$];
    bit            pix[N];
    logic [LW-1:0] resp_lbl[N];
    bit            resp_new[N];
    int            n_vec = 0;
    int            n_fail = 0;
    bit            chk_spacing = 0;
    int            start_cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Expected neighbours from pixel positions: left = previous write-back in the row, top = same column one row up.
    task automatic push_model();
        logic [LW-1:0] wbv[N];
        exp_t          e;
        for (int i = 0; i < N; i++) wbv[i] = pix[i] ? resp_lbl[i] : '0;
        for (int i = 0; i < N; i++) begin
            e.m   = pix[i];
            e.l   = (i % W == 0) ? '0 : wbv[(i + N - 1) % N];
            e.t   = (i < W) ? '0 : wbv[(i + N - W) % N];
            e.idx = i;
            sb.push_back(e);
        end
    endtask

    task automatic monitor_loop();
        exp_t          e;
        logic [LW-1:0] l;
        bit            n;
        int            lab_idx = 0;
        int            last_en = 0;
        bit            have_last = 0;
        forever begin
            @(negedge clk);
            if (!rst || !busy) begin
                lab_idx   = 0;
                have_last = 0;
            end
            if (rst && lbl_enable) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL unexpected_strobe: got lbl_enable, expected none (t=%0t)", $time);
                end else begin
                    e = sb.pop_front();
                    chk($sformatf("pix%0d_motion", e.idx), 32'(lbl_motion_pixel), 32'(e.m));
                    chk($sformatf("pix%0d_left", e.idx), 32'(lbl_left_label), 32'(e.l));
                    chk($sformatf("pix%0d_top", e.idx), 32'(lbl_top_label), 32'(e.t));
                end
                if (chk_spacing && have_last) chk("strobe_spacing", cyc - last_en, 3);
                last_en   = cyc;
                have_last = 1;
                l = resp_lbl[lab_idx % N];
                n = resp_new[lab_idx % N];
                lab_idx++;
                @(posedge clk);
                #1;
                lbl_current_label   = l;
                lbl_new_label_valid = n;
                @(posedge clk);
                #1;
                lbl_current_label   = '0;
                lbl_new_label_valid = 1'b0;
            end
        end
    endtask

    task automatic run_frame(input string nm, input int gap_at, input int abort_at,
                             input int exp_cnt, input bit exp_ovf);
        bit ok;
        push_model();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        start_cyc = cyc;
        @(negedge clk);
        chk($sformatf("%s_start_state", nm), 32'({label_count, label_overflow, busy}), 32'(4'b0001));
        for (int i = 0; i < N; i++) begin
            if (i == gap_at) begin
                pix_valid = 1'b0;
                ok = 0;
                for (int c = 0; c < 10; c++) begin
                    @(negedge clk);
                    if (pix_ready) begin
                        ok = 1;
                        break;
                    end
                end
                chk("gap_reach_fetch", 32'(ok), 1);
                for (int k = 0; k < 5; k++) begin
                    chk("gap_hold_fetch", 32'({pix_ready, lbl_enable}), 32'(2'b10));
                    @(negedge clk);
                end
            end
            pix_valid = 1'b1;
            pix_data  = pix[i];
            ok = 0;
            for (int c = 0; c < 10; c++) begin
                if (pix_ready) begin
                    ok = 1;
                    break;
                end
                @(negedge clk);
            end
            if (!ok) chk($sformatf("%s_ready_pix%0d", nm, i), 32'(ok), 1);
            @(posedge clk);
            #1;
            if (i == abort_at) begin
                pix_valid = 1'b0;
                @(negedge clk);
                chk("abort_in_issue", 32'(lbl_enable), 1);
                #1 rst = 1'b0;
                #1;
                chk("abort_outputs", 32'({pix_ready, lbl_enable, lbl_motion_pixel, lbl_left_label,
                    lbl_top_label, busy, frame_done, label_count, label_overflow}), 0);
                repeat (2) @(negedge clk);
                chk("abort_held_idle", 32'({busy, frame_done, pix_ready}), 0);
                sb.delete();
                rst = 1'b1;
                return;
            end
        end
        pix_valid = 1'b0;
        ok = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (frame_done) begin
                ok = 1;
                break;
            end
        end
        chk($sformatf("%s_done_seen", nm), 32'(ok), 1);
        if (ok) begin
            if (gap_at < 0) chk($sformatf("%s_done_latency", nm), cyc - start_cyc + 1, 37);
            chk($sformatf("%s_label_count", nm), 32'(label_count), exp_cnt);
            chk($sformatf("%s_overflow", nm), 32'(label_overflow), 32'(exp_ovf));
            chk($sformatf("%s_all_strobes", nm), sb.size(), 0);
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            @(negedge clk);
            chk($sformatf("%s_start_at_done_ignored", nm), 32'({busy, label_overflow}), 32'({1'b0, exp_ovf}));
        end
    endtask

    initial begin
        fork
            monitor_loop();
        join_none
        #12;
        chk("reset_outputs", 32'({pix_ready, lbl_enable, lbl_motion_pixel, lbl_left_label,
            lbl_top_label, busy, frame_done, label_count, label_overflow}), 0);
        @(negedge clk);
        rst = 1'b1;

        // All-zero frame; labeler offers 3 but background must write back 0.
        for (int i = 0; i < N; i++) begin
            pix[i] = 0; resp_lbl[i] = 2'd3; resp_new[i] = 0;
        end
        chk_spacing = 1;
        run_frame("allzero", -1, -1, 0, 0);
        chk_spacing = 0;

        // Single motion pixel at (2,1): (3,1) sees left=1, (2,2) sees top=1.
        pix[6] = 1; resp_lbl[6] = 2'd1; resp_new[6] = 1;
        run_frame("single", -1, -1, 1, 0);

        // All-motion frames twice: second frame must mask stale labels at row 0 / column 0.
        for (int i = 0; i < N; i++) begin
            pix[i] = 1; resp_lbl[i] = 2'd2; resp_new[i] = (i == 0);
        end
        run_frame("edgeA", -1, -1, 1, 0);
        run_frame("edgeB", -1, -1, 1, 0);

        // Varying labels expose the x/y walk; pix_valid withdrawn before pixel 5.
        for (int i = 0; i < N; i++) begin
            pix[i] = 1; resp_lbl[i] = LW'((i % 3) + 1); resp_new[i] = 0;
        end
        run_frame("gap", 5, -1, 0, 0);

        // Four new labels in 2-bit space: count saturates at 3 and overflow sticks.
        for (int i = 0; i < N; i++) begin
            pix[i] = (i < 4); resp_lbl[i] = (i < 4) ? LW'((i > 2) ? 3 : i + 1) : '0; resp_new[i] = (i < 4);
        end
        run_frame("sat", -1, -1, 3, 1);

        // Reset during ISSUE of the fifth pixel, then a clean frame.
        for (int i = 0; i < N; i++) begin
            pix[i] = 1; resp_lbl[i] = 2'd2; resp_new[i] = (i == 0);
        end
        run_frame("abort", -1, 4, 0, 0);
        for (int i = 0; i < N; i++) begin
            pix[i] = 0; resp_lbl[i] = '0; resp_new[i] = 0;
        end
        run_frame("clean", -1, -1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/labeler_scan_ctrl.md
# labeler_scan_ctrl

Raster-scan sequencer for the connected-component labeler in the bounding-box path. Accepts a stream of binary motion pixels and walks the frame with x/y counters. For each pixel it presents the labeler with the pixel plus its left and top neighbour labels, then captures the returned label into a one-row label line buffer. It also counts allocated labels, flags label-space exhaustion and frames each scan with start/done signalling.

## Interface
- IMG_W, 64: pixels per row (≥2)
- IMG_H, 48: rows per frame (≥2)
- LABEL_WIDTH, 8: label width; label 0 = background
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-low reset
- start  input  1  one-cycle pulse; begins a frame when idle
- pix_valid  input  1  motion pixel available
- pix_data  input  1  motion pixel value
- pix_ready  output  1  controller accepts pixel this cycle
- lbl_enable  output  1  one-cycle labeler strobe
- lbl_motion_pixel  output  1  pixel presented to labeler
- lbl_left_label  output  LABEL_WIDTH  left neighbour label
- lbl_top_label  output  LABEL_WIDTH  top neighbour label
- lbl_current_label  input  LABEL_WIDTH  labeler result, valid one cycle after lbl_enable
- lbl_new_label_valid  input  1  labeler allocated a label, same cycle as result
- busy  output  1  frame in progress
- frame_done  output  1  one-cycle pulse after last pixel written back
- label_count  output  LABEL_WIDTH  labels allocated this frame, saturating
- label_overflow  output  1  sticky, label space exhausted

## Operation
- FSM states: IDLE, FETCH, ISSUE, WRITE, DONE.
- IDLE: pix_ready=0. On start, load x=0, y=0, left_reg=0, label_count=0, label_overflow=0, then go to FETCH.
- FETCH: pix_ready=1. On pix_valid, register pix_data, issue a synchronous read of line_buf[x], then go to ISSUE. Without pix_valid, stay in FETCH.
- ISSUE: lbl_enable=1 for exactly one cycle.
  - lbl_motion_pixel = registered pixel.
  - lbl_left_label = (x==0) ? 0 : left_reg.
  - lbl_top_label = (y==0) ? 0 : line_buf read data.
  - Go to WRITE.
- WRITE: wb = pixel ? lbl_current_label : 0 (background is forced to 0).
  - Write line_buf[x] = wb and left_reg = wb.
  - If lbl_new_label_valid: increment label_count. At all-ones, hold the value and set label_overflow.
  - Advance counters. If x==IMG_W-1, set x=0 and increment y; otherwise increment x.
  - After the pixel at (IMG_W-1, IMG_H-1), go to DONE. Otherwise go to FETCH.
- DONE: frame_done=1 for one cycle, then go to IDLE.
- The line buffer is never cleared. Row 0 forces top=0, and x==0 forces left=0, so stale contents from a previous frame are never observed.
- Counter widths: x is $clog2(IMG_W) bits and y is $clog2(IMG_H) bits. Both wrap only via the explicit compare.
- start outside IDLE is ignored.
- pix_valid outside FETCH is ignored; no pixel is consumed.

## Timing
- Reset values: FSM=IDLE. pix_ready, lbl_enable, lbl_motion_pixel, busy, frame_done, label_overflow = 0. lbl_left_label, lbl_top_label, label_count = 0. x, y, left_reg = 0. Line buffer is not reset.
- Throughput is 3 cycles per pixel with continuous pix_valid.
- A full frame is IMG_W·IMG_H·3 cycles plus 1 cycle of DONE after start.
- Handshake: a pixel transfers on the rising edge where pix_valid && pix_ready.
- busy=1 in FETCH, ISSUE, WRITE and DONE.
- frame_done asserts 1 cycle after the last WRITE.
- A start pulse coincident with the frame_done cycle is ignored. start is accepted from the following cycle (IDLE).
- Reset asserted mid-frame returns to IDLE immediately. Outputs clear asynchronously. A partial frame is abandoned and no frame_done is issued.
- lbl_left/top_label are held at 0 outside ISSUE.

## Test plan
- IMG_W=4, IMG_H=3, all-zero frame:
  - 12 lbl_enable pulses, each spaced 3 cycles apart.
  - All left/top labels = 0; label_count=0.
  - frame_done occurs exactly 37 cycles after the start edge.
- Single motion pixel at (2,1), labeler model returns 1 with new_label_valid:
  - label_count=1.
  - Pixel (2,2) sees top=1.
  - Pixel (3,1) sees left=1.
- Row 0 / column 0 boundary with a new frame after a frame that left labels in the buffer:
  - Every row-0 ISSUE shows top=0.
  - Every x=0 ISSUE shows left=0.
- pix_valid toggled off for 5 cycles in FETCH:
  - FSM stays in FETCH; no lbl_enable pulses.
  - Resumes on pix_valid, with the correct x/y sequence.
- LABEL_WIDTH=2, labeler asserts new_label_valid on 4 pixels:
  - label_count saturates at 3.
  - label_overflow=1 until the next start, which clears both.
- rst pulled low during ISSUE of pixel 5:
  - All outputs are 0 the same cycle; FSM is in IDLE.
  - A following start gives a clean 12-pixel frame.
